seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider for the adder/arithmetic library; the inverse-direction partner to the combinational add/sub datapath.
- Accepts dividend/divisor on a start pulse, produces one quotient bit per clock using shift-and-subtract, then reports quotient and remainder with a done pulse.
- Used wherever a divide is needed and single-cycle area is not justified.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (must be >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled on a clk edge only when the block is not busy.
- dividend  input  WIDTH  unsigned numerator; captured with start.
- divisor  input  WIDTH  unsigned denominator; captured with start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor was 0; held with the results.

Behaviour:
- Reset (asynchronous, active-high) forces the following; reset mid-division aborts with no done pulse:
  - state = IDLE;
  - busy = 0, done = 0, div_by_zero = 0;
  - quotient = 0, remainder = 0;
  - internal counter and shift registers = 0.
- States and transitions:
  - IDLE -> RUN on start with divisor != 0.
  - IDLE -> DONE on start with divisor == 0.
  - RUN -> DONE after WIDTH iterations.
  - DONE -> IDLE unconditionally after one cycle.
- Accept rule: start is accepted in IDLE and in DONE, so back-to-back operations are allowed.
  - In DONE, a start takes the same transition as from IDLE instead of returning to IDLE.
  - start while in RUN is ignored with no side effects; operands are not re-captured.
- On accept:
  - register divisor into D;
  - Q = dividend;
  - R (WIDTH+1 bits) = 0;
  - counter = WIDTH-1;
  - clear div_by_zero.
- RUN iteration, one per cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]};
  - if T >= {0,D}: R = T - D and qbit = 1; else R = T and qbit = 0;
  - Q = {Q[WIDTH-2:0], qbit};
  - decrement counter;
  - the iteration with counter == 0 is the last one, and the next state is DONE.
- Latency:
  - normal operation: done is high in the cycle following the WIDTH-th edge after the accepting edge;
  - divide by zero: done is high in the cycle following the accepting edge.
- DONE outputs:
  - quotient = Q, remainder = R[WIDTH-1:0], done = 1;
  - busy = 0 in DONE; busy = 1 only in RUN.
- Divide-by-zero:
  - quotient = all ones, remainder = dividend, div_by_zero = 1;
  - no RUN cycles.
- Outputs are registered; no combinational path from inputs to outputs.
- Operands may change freely after the accepting edge.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the counter-width constant, $clog2(WIDTH).
- Sub-module div_step: combinational single iteration.
  - Inputs: R, Q MSB and D.
  - Outputs: next R and qbit.
  - Isolates compare/subtract for reuse and unit test.
- The top level holds the FSM, counter and registers.

Test Plan:
- Reset, then dividend=13, divisor=3, start for one cycle -> busy high for 4 cycles; done pulse; quotient=4, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 -> quotient=15, remainder=0.
- dividend=5, divisor=7 -> quotient=0, remainder=5.
- dividend=9, divisor=0 -> done one cycle after accept; quotient=1111, remainder=1001, div_by_zero=1; busy never high.
- start 12/5 and, two cycles later, start 15/15 while busy -> second ignored; result quotient=2, remainder=2. Then start 15/15 in the DONE cycle -> accepted; quotient=1, remainder=0.
- Assert rst during RUN of 14/3 -> all outputs 0 immediately; no done. A following 14/3 gives quotient=4, remainder=2.
- Exhaustive sweep of all 256 operand pairs at WIDTH=4 -> matches reference arithmetic (/ and %); zero divisor per the rule above.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t      : FSM encoding (IDLE, RUN, DONE)
//   cnt_width()  : iteration-counter width for a given operand width
//   CNT_W        : counter width for the default 4-bit configuration
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // The counter runs WIDTH-1 down to 0, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   r      : partial remainder (low WIDTH bits of R)
//   q_msb  : bit shifted in from the dividend/quotient register
//   d      : divisor
//   r_next : partial remainder after the compare/subtract
//   qbit   : quotient bit produced by this iteration
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             qbit
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;

  assign t    = {r, q_msb};
  assign diff = t - {1'b0, d};

  // No borrow out of the (WIDTH+1)-bit subtract means T >= D.
  assign qbit = ~diff[WIDTH];

  // The restored remainder is always below D, so it fits in WIDTH bits.
  assign r_next = qbit ? diff[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request; accepted in IDLE or DONE, ignored in RUN
//   dividend     : numerator, captured on the accepting edge
//   divisor      : denominator, captured on the accepting edge
//   busy         : high only in RUN
//   done         : one-cycle pulse (the DONE state)
//   quotient     : result, held until replaced by the next result
//   remainder    : result, held until replaced by the next result
//   div_by_zero  : set with done when the divisor was 0
//   dbg_state    : current FSM state, for observation
//
// Handshake: start is a level sampled on each rising edge; it is consumed
// on any edge where the block is not in RUN. done marks the cycle in which
// quotient/remainder/div_by_zero first show the new result.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output state_t           dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  // R is conceptually WIDTH+1 bits, but after each restoring step its top
  // bit is zero, so only the low WIDTH bits are stored.
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic [WIDTH-1:0] r_step;
  logic             qbit;
  logic [WIDTH-1:0] q_step;

  assign accept = start && (state != RUN);

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .d      (d_reg),
    .r_next (r_step),
    .qbit   (qbit)
  );

  assign q_step = {q_reg[WIDTH-2:0], qbit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        // A start here chains directly into the next operation.
        if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_reg       <= divisor;
      q_reg       <= dividend;
      r_reg       <= '0;
      cnt         <= CW'(WIDTH - 1);
      div_by_zero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      r_reg <= r_step;
      q_reg <= q_step;
      cnt   <= cnt - 1'b1;
      if (cnt == '0) begin
        quotient  <= q_step;
        remainder <= r_step;
      end
    end
  end

  // Decoded straight from the state register: no input-to-output path.
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  state_t       dbg_state;

  int n_vec;
  int n_err;

  // Expected {div_by_zero, quotient, remainder} per accepted operation.
  logic [2*W:0] exp_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic, with the divide-by-zero convention.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int qa;
    int ra;
    if (b == 0) return {1'b1, {W{1'b1}}, a};
    qa = int'(a) / int'(b);
    ra = int'(a) % int'(b);
    return {1'b0, W'(qa), W'(ra)};
  endfunction

  task automatic check_result(input string tag);
    logic [2*W:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_q"},   32'(quotient),    32'(e[2*W-1:W]));
    check({tag, "_r"},   32'(remainder),   32'(e[W-1:0]));
    check({tag, "_dz"},  32'(div_by_zero), 32'(e[2*W]));
  endtask

  // Caller sits at a negedge with start already driven. Counts negedges
  // until done (bounded), dropping start and scrambling operands after the
  // first edge so capture is exercised.
  task automatic wait_done(output int cyc, output int bcyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    bcyc = 0;
    for (int k = 0; k < 24 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      if (busy) bcyc++;
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(ref_div(a, b));
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int cyc;
    int bcyc;
    drive_start(a, b);
    wait_done(cyc, bcyc);
    check({tag, "_lat"},  32'(cyc),  (b == 0) ? 32'd1 : 32'(W + 1));
    check({tag, "_busy"}, 32'(bcyc), (b == 0) ? 32'd0 : 32'(W));
    check_result(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int bcyc;
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_q",     32'(quotient),    32'd0);
    check("rst_r",     32'(remainder),   32'd0);
    check("rst_dz",    32'(div_by_zero), 32'd0);
    check("rst_state", 32'(dbg_state),   32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_div(4'd13, 4'd3, "d13_3");
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    do_div(4'd15, 4'd1, "d15_1");
    do_div(4'd5,  4'd7, "d5_7");
    do_div(4'd9,  4'd0, "d9_0");

    // start while busy is ignored; start in DONE chains
    drive_start(4'd12, 4'd5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 4'd15;
    divisor  = 4'd15;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcyc);
    check("ign_lat", 32'(cyc), 32'd2);
    check_result("ign");
    drive_start(4'd15, 4'd15);
    wait_done(cyc, bcyc);
    check("chain_lat", 32'(cyc), 32'(W + 1));
    check_result("chain");

    // Reset mid-division
    drive_start(4'd14, 4'd3);
    void'(exp_q.pop_back());
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_busy",  32'(busy),        32'd0);
    check("mrst_done",  32'(done),        32'd0);
    check("mrst_q",     32'(quotient),    32'd0);
    check("mrst_r",     32'(remainder),   32'd0);
    check("mrst_dz",    32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int saw;
      saw = 0;
      repeat (W + 2) begin
        @(negedge clk);
        if (done) saw++;
      end
      check("mrst_nodone", 32'(saw), 32'd0);
    end
    do_div(4'd14, 4'd3, "post_rst");

    // Exhaustive sweep
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        do_div(W'(a), W'(b), "sweep");
      end
    end

    // Random operands, random gaps, random chaining from DONE
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        int gap;
        gap = $urandom_range(1, 3);
        repeat (gap) @(negedge clk);
      end
      do_div(W'($urandom), ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom), "rand");
    end

    @(negedge clk);
    check("end_idle", 32'(dbg_state), 32'(IDLE));
    check("end_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
